shader_program_loader: RTL and testbench
========================================

# shader_program_loader

Writer side of the shader instruction memory: accepts a byte stream carrying a shader program, assembles 32-bit instruction words MSB-first and writes them into the 16-entry instruction memory that the processor core fetches from by `pc`. While a load is in progress it holds the core. After the last program word it zero-fills the remaining entries, so every unused slot is a NOP-equivalent all-zero word.

## Interface
Parameters:
- `DEPTH`, 16: instruction memory entries.
- `ADDR_W`, 4: instruction memory address width; DEPTH == 2**ADDR_W.

Ports:
- `clk`  in  1  the only clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle request to begin a load session; honoured only in IDLE.
- `in_valid`  in  1  byte stream valid.
- `in_data`  in  8  byte stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  ADDR_W  instruction memory write address.
- `imem_wdata`  out  32  instruction word to write.
- `core_hold`  out  1  stalls the core; high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of every session.
- `error`  out  1  sticky error flag; cleared when the next `start` is accepted.
- `words_loaded`  out  ADDR_W+1  number of program words written in the current or last session.

## Operation
- States: IDLE, HDR, LOAD, WRITE, FILL, DONE.
- IDLE: `start`=1 moves to HDR and clears `error`, `words_loaded`, the byte counter and the word index. `start` in any other state is ignored.
- HDR: the first accepted byte is the word count N.
  - N==0 or N>DEPTH: set `error`, go to DONE. No memory writes occur.
  - Otherwise latch N and go to LOAD.
- LOAD: accepts bytes into a shift register, MSB first (byte0 goes to [31:24], byte3 to [7:0]). After the 4th byte of a word is accepted, go to WRITE.
- WRITE: one cycle with `imem_we`=1, `imem_addr`=word index, `imem_wdata`=assembled word.
  - Field check: bits [16:0] are reserved and must be 0. If any reserved bit is 1, set `error`; the word is still written, with [16:0] forced to 0.
  - Increment the word index and `words_loaded`.
  - If the index has reached N: go to FILL, or to DONE if N==DEPTH. Otherwise return to LOAD.
- FILL: one write per cycle with `imem_we`=1, `imem_wdata`=0, addresses N..DEPTH-1 ascending. After address DEPTH-1, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `in_ready` is 1 only in HDR and LOAD, and is decoded from state alone (never depends on `in_valid`). A byte is transferred on a posedge where `in_valid` && `in_ready`. `in_data` is ignored when no transfer occurs.
- Bytes offered in IDLE, WRITE, FILL or DONE are not accepted. The upstream source must hold them (valid/ready rule: once `in_valid` is asserted it stays high with stable data until transfer).

## Timing
- Reset values: state IDLE; `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_hold`=0, `done`=0, `error`=0, `words_loaded`=0. All outputs are registered or decoded from registered state.
- `start` sampled at edge t: `core_hold` and `in_ready` are 1 from t+1.
- With `in_valid` held high, each word takes 5 cycles (4 accept cycles plus 1 WRITE). The write is visible at the edge ending the WRITE cycle.
- Full session cycle count from the `start` edge: 1 (HDR) + 5N + (DEPTH−N) (FILL) + 1 (DONE), assuming no source stalls.
- `core_hold` falls in the cycle after DONE, together with the return to IDLE.
- `rst` asserted mid-session: immediate abort with no further writes; partially written memory is left as-is, and all outputs go to reset values.
- `start` and `rst` together: reset wins.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; `in_ready`=0 while in IDLE.
- Load N=2 with words 0x3C000000 and 0x57E00000, `in_valid` always high -> writes addr0=0x3C000000, addr1=0x57E00000, then zeros to addr2..15; `done` pulses 1+10+14+1=26 cycles after `start`; `error`=0; `words_loaded`=2.
- N=16 -> exactly 16 data writes, no FILL cycles, `words_loaded`=16; `done` pulses 82 cycles after `start`.
- Header 0x00, then a separate session with header 0x11 -> each session: `error`=1, `done` pulses, no `imem_we`, `core_hold` lasts 3 cycles.
- Word 0x00000001 with N=1 -> addr0 written as 0x00000000, `error`=1 and held through the following IDLE; next accepted `start` clears `error`.
- `in_valid` toggling 1/0 per cycle with N=1, plus `start` pulsed during LOAD, then `rst` asserted during FILL at addr 7 -> word assembled correctly, stray `start` ignored, no writes after reset, `core_hold`=0.

Source files
------------

// File: rtl/shader_program_loader_if.sv
// Loader-side bundle: upstream byte stream, instruction memory write port and core stall/status.
interface shader_program_loader_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_hold, done, error, words_loaded
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_hold, done, error, words_loaded
  );
endinterface

// File: rtl/shader_program_loader.sv
// Loads a byte-streamed shader program into instruction memory MSB-first,
// zero-fills unused slots and stalls the core for the whole session.
module shader_program_loader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  shader_program_loader_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, HDR, LOAD, WRITE, FILL, DONE} state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift_q;
  logic             rsvd_bad;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_idx;

  logic        xfer;
  logic [31:0] word_c;

  assign xfer   = bus.in_valid && bus.in_ready;
  assign word_c = {shift_q, bus.in_data};

  // Handshake and stall are pure decodes of the registered state.
  assign bus.in_ready     = (state == HDR) || (state == LOAD);
  assign bus.core_hold    = (state != IDLE);
  assign bus.words_loaded = word_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      byte_cnt       <= 2'd0;
      shift_q        <= 24'd0;
      rsvd_bad       <= 1'b0;
      n_words        <= '0;
      word_idx       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= HDR;
            bus.error <= 1'b0;
            word_idx  <= '0;
            byte_cnt  <= 2'd0;
          end
        end
        HDR: begin
          if (xfer) begin
            if (bus.in_data == 8'd0 || bus.in_data > 8'(DEPTH)) begin
              bus.error <= 1'b1;
              bus.done  <= 1'b1;
              state     <= DONE;
            end else begin
              n_words <= CNT_W'(bus.in_data);
              state   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            shift_q  <= word_c[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Reserved field is forced to zero on the way out; the flag remembers the violation.
              rsvd_bad       <= |word_c[16:0];
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_idx[ADDR_W-1:0];
              bus.imem_wdata <= {word_c[31:17], 17'd0};
              state          <= WRITE;
            end
          end
        end
        WRITE: begin
          if (rsvd_bad) begin
            bus.error <= 1'b1;
          end
          word_idx <= word_idx + CNT_W'(1);
          if (word_idx + CNT_W'(1) == n_words) begin
            if (n_words == CNT_W'(DEPTH)) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= n_words[ADDR_W-1:0];
              bus.imem_wdata <= 32'd0;
              state          <= FILL;
            end
          end else begin
            state <= LOAD;
          end
        end
        FILL: begin
          if (bus.imem_addr == ADDR_W'(DEPTH - 1)) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            bus.imem_we   <= 1'b1;
            bus.imem_addr <= bus.imem_addr + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shader_program_loader.sv
// Directed bench for shader_program_loader: expected memory writes are queued at stimulus time
// and matched against the write strobes the loader actually produces.
module tb_shader_program_loader;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shader_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  shader_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  rd_idx   = 0;
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  hold_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe write strobes, done pulses and stall cycles mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_t w;
      w.addr = bus.imem_addr;
      w.data = bus.imem_wdata;
      obs_q.push_back(w);
    end
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (bus.core_hold === 1'b1) hold_cnt = hold_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(output int sc);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    sc = cyc;
  endtask

  // Offer bytes; with toggle set, valid drops for one cycle after every transfer.
  task automatic feed(input logic [7:0] bytes[$], input bit toggle);
    int idx   = 0;
    int guard = 0;
    bit gap   = 1'b0;
    bit x;
    while (idx < bytes.size() && guard < 400) begin
      if (toggle && gap) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = bytes[idx];
      end
      x = bus.in_valid && (bus.in_ready === 1'b1);
      @(negedge clk);
      gap = x;
      if (x) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("feed_complete", 64'(idx), 64'(bytes.size()));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int i  = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(tag, 64'(done_cnt - d0), 64'(1));
  endtask

  task automatic compare_writes(input string tag);
    wr_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) begin
        chk({tag, "_addr"}, 64'(obs_q[rd_idx].addr), 64'(e.addr));
        chk({tag, "_data"}, 64'(obs_q[rd_idx].data), 64'(e.data));
        rd_idx++;
      end else begin
        chk({tag, "_missing"}, 64'(obs_q.size()), 64'(rd_idx + 1));
      end
    end
    chk({tag, "_extra"}, 64'(obs_q.size()), 64'(rd_idx));
  endtask

  initial begin
    int          sc;
    int          h0;
    int          w0;
    int          g;
    logic [31:0] w;
    logic [7:0]  bq[$];
    logic [7:0]  hdrs[2];

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    // Reset applied between clock edges must clear outputs at once.
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),     64'(0));
    chk("rst_we",        64'(bus.imem_we),      64'(0));
    chk("rst_addr",      64'(bus.imem_addr),    64'(0));
    chk("rst_wdata",     64'(bus.imem_wdata),   64'(0));
    chk("rst_hold",      64'(bus.core_hold),    64'(0));
    chk("rst_done",      64'(bus.done),         64'(0));
    chk("rst_error",     64'(bus.error),        64'(0));
    chk("rst_words",     64'(bus.words_loaded), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // N=2, valid held high throughout.
    exp_push(0, 32'h3C00_0000);
    exp_push(1, 32'h57E0_0000);
    for (int a = 2; a < int'(DEPTH); a++) exp_push(a, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h02;
    h0 = hold_cnt;
    pulse_start(sc);
    chk("n2_hold_after_start",  64'(bus.core_hold), 64'(1));
    chk("n2_ready_after_start", 64'(bus.in_ready),  64'(1));
    feed('{8'h02, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h57, 8'hE0, 8'h00, 8'h00}, 1'b0);
    wait_done(100, "n2_done");
    chk("n2_done_latency", 64'(done_cyc - sc), 64'(25));
    @(negedge clk);
    #1;
    chk("n2_done_single", 64'(bus.done),      64'(0));
    chk("n2_hold_release", 64'(bus.core_hold), 64'(0));
    chk("n2_hold_cycles", 64'(hold_cnt - h0), 64'(26));
    compare_writes("n2");
    chk("n2_error", 64'(bus.error),        64'(0));
    chk("n2_words", 64'(bus.words_loaded), 64'(2));

    // N=DEPTH: no fill phase.
    bq.delete();
    bq.push_back(8'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) begin
      w = $urandom() & 32'hFFFE_0000;
      exp_push(i, w);
      bq.push_back(w[31:24]);
      bq.push_back(w[23:16]);
      bq.push_back(w[15:8]);
      bq.push_back(w[7:0]);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(DEPTH);
    h0 = hold_cnt;
    pulse_start(sc);
    feed(bq, 1'b0);
    wait_done(200, "n16_done");
    chk("n16_done_latency", 64'(done_cyc - sc), 64'(81));
    @(negedge clk);
    #1;
    chk("n16_hold_cycles", 64'(hold_cnt - h0), 64'(82));
    compare_writes("n16");
    chk("n16_words", 64'(bus.words_loaded), 64'(16));
    chk("n16_error", 64'(bus.error),        64'(0));

    // Illegal headers; the header is offered one cycle after start, so HDR lasts two cycles.
    hdrs[0] = 8'h00;
    hdrs[1] = 8'h11;
    for (int k = 0; k < 2; k++) begin
      h0 = hold_cnt;
      w0 = obs_q.size();
      pulse_start(sc);
      @(negedge clk);
      feed('{hdrs[k]}, 1'b0);
      wait_done(20, "hdr_done");
      chk("hdr_done_latency", 64'(done_cyc - sc), 64'(2));
      @(negedge clk);
      #1;
      chk("hdr_error",       64'(bus.error),          64'(1));
      chk("hdr_hold_cycles", 64'(hold_cnt - h0),      64'(3));
      chk("hdr_no_writes",   64'(obs_q.size()),       64'(w0));
    end

    // Reserved bit set: word written with reserved field cleared, error sticks in IDLE.
    exp_push(0, 32'd0);
    for (int a = 1; a < int'(DEPTH); a++) exp_push(a, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    pulse_start(sc);
    feed('{8'h01, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
    wait_done(60, "rsvd_done");
    @(negedge clk);
    #1;
    compare_writes("rsvd");
    chk("rsvd_error", 64'(bus.error),        64'(1));
    chk("rsvd_words", 64'(bus.words_loaded), 64'(1));
    repeat (5) @(negedge clk);
    chk("rsvd_error_sticky", 64'(bus.error), 64'(1));

    // Toggling valid, stray start mid-word, then reset during the fill at address 7.
    exp_push(0, 32'hA5F6_0000);
    for (int a = 1; a <= 7; a++) exp_push(a, 32'd0);
    pulse_start(sc);
    chk("start_clears_error", 64'(bus.error),     64'(0));
    chk("tog_hold",           64'(bus.core_hold), 64'(1));
    @(negedge clk);
    feed('{8'h01, 8'hA5, 8'hF6}, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("stray_start_ready", 64'(bus.in_ready), 64'(1));
    feed('{8'h00, 8'h00}, 1'b1);
    g = 0;
    while (!(bus.imem_we === 1'b1 && bus.imem_addr == ADDR_W'(7)) && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("fill_addr7_reached", 64'(bus.imem_addr), 64'(7));
    chk("tog_words",          64'(bus.words_loaded), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("abort_we",       64'(bus.imem_we),      64'(0));
    chk("abort_hold",     64'(bus.core_hold),    64'(0));
    chk("abort_ready",    64'(bus.in_ready),     64'(0));
    chk("abort_done",     64'(bus.done),         64'(0));
    chk("abort_words",    64'(bus.words_loaded), 64'(0));
    chk("abort_addr",     64'(bus.imem_addr),    64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    compare_writes("abort");
    chk("abort_idle_hold", 64'(bus.core_hold), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
